// File: rtl/ram2_arbiter_pkg.sv
// Shared encodings for the RAM2 SRAM arbiter: FSM states, grant owner and a sizing helper.
package ram2_arbiter_pkg;

   typedef enum logic [1:0] {
      Ram2Idle,
      Ram2Read,
      Ram2Write,
      Ram2Done
   } ram2_state_e;

   typedef enum logic {
      GrantIf,
      GrantMem
   } ram2_grant_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ram2_ibuf.sv
// Single-entry instruction buffer for the RAM2 arbiter: stores the last fetched
// {addr, data} and drops it when MEM writes the same address.
module ram2_ibuf #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [ADDR_W-1:0] i_load_addr,
   input  logic [DATA_W-1:0] i_load_data,
   input  logic              i_inv,
   input  logic [ADDR_W-1:0] i_inv_addr,
   input  logic [ADDR_W-1:0] i_lookup_addr,
   output logic              o_hit,
   output logic [DATA_W-1:0] o_data
);

   logic              r_valid;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
      end else if (i_inv && (i_inv_addr == r_addr)) begin
         r_valid <= 1'b0;
      end
   end

   // NOTE: the entry payload carries no reset; r_valid alone guards its use.
   always_ff @(posedge clk) begin
      if (i_load) begin
         r_addr <= i_load_addr;
         r_data <= i_load_data;
      end
   end

   assign o_hit  = r_valid && (i_lookup_addr == r_addr);
   assign o_data = r_data;

endmodule

// File: rtl/ram2_arbiter.sv
// RAM2 single-port SRAM sequencer shared by IF and MEM (MEM has fixed priority).
// Optional RAM2_IBUF_EN adds a one-entry instruction buffer that short-circuits repeat fetches.
module ram2_arbiter
   import ram2_arbiter_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int SRAM_AW   = 18,
   parameter int RD_CYCLES = 2,
   parameter int WR_CYCLES = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               if_req,
   input  logic [ADDR_W-1:0]  if_addr,
   output logic [DATA_W-1:0]  if_inst,
   output logic               if_ready,
   input  logic               mem_req,
   input  logic               mem_we,
   input  logic [ADDR_W-1:0]  mem_addr,
   input  logic [DATA_W-1:0]  mem_wdata,
   output logic [DATA_W-1:0]  mem_rdata,
   output logic               mem_ready,
   output logic               stall_req,
   output logic [SRAM_AW-1:0] sram_addr,
   input  logic [DATA_W-1:0]  sram_dq_i,
   output logic [DATA_W-1:0]  sram_dq_o,
   output logic               sram_dq_oe,
   output logic               sram_en_n,
   output logic               sram_oe_n,
   output logic               sram_we_n
);

   localparam int CNT_W = $clog2(max_int(RD_CYCLES, WR_CYCLES));
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
   localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);

   ram2_state_e        r_state;
   ram2_state_e        w_next_state;
   ram2_grant_e        r_grant;
   logic [CNT_W-1:0]   r_cnt;
   logic [SRAM_AW-1:0] r_addr;
   logic [DATA_W-1:0]  r_wdata;
   logic [DATA_W-1:0]  r_if_inst;
   logic [DATA_W-1:0]  r_mem_rdata;
   logic               w_rd_last;
   logic               w_wr_last;
   logic               w_ibuf_hit;
   logic [DATA_W-1:0]  w_ibuf_data;

   assign w_rd_last = (r_state == Ram2Read)  && (r_cnt == RD_LAST);
   assign w_wr_last = (r_state == Ram2Write) && (r_cnt == WR_LAST);

`ifdef RAM2_IBUF_EN
   logic w_ibuf_load;
   logic w_ibuf_inv;

   assign w_ibuf_load = w_rd_last && (r_grant == GrantIf);
   assign w_ibuf_inv  = (r_state == Ram2Idle) && mem_req && mem_we;

   ram2_ibuf #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ibuf (
      .clk           (clk),
      .rst           (rst),
      .i_load        (w_ibuf_load),
      .i_load_addr   (r_addr[ADDR_W-1:0]),
      .i_load_data   (sram_dq_i),
      .i_inv         (w_ibuf_inv),
      .i_inv_addr    (mem_addr),
      .i_lookup_addr (if_addr),
      .o_hit         (w_ibuf_hit),
      .o_data        (w_ibuf_data)
   );
`else
   assign w_ibuf_hit  = 1'b0;
   assign w_ibuf_data = '0;
`endif

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         Ram2Idle: begin
            if (mem_req) begin
               w_next_state = mem_we ? Ram2Write : Ram2Read;
            end else if (if_req) begin
               w_next_state = w_ibuf_hit ? Ram2Done : Ram2Read;
            end
         end
         Ram2Read:  if (w_rd_last) w_next_state = Ram2Done;
         Ram2Write: if (w_wr_last) w_next_state = Ram2Done;
         Ram2Done:  w_next_state = Ram2Idle;
         default:   w_next_state = Ram2Idle;
      endcase
   end

   // NOTE: sequential state uses <= only, so every read here sees pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= Ram2Idle;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         if ((w_next_state == r_state) && ((r_state == Ram2Read) || (r_state == Ram2Write))) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end else begin
            r_cnt <= '0;
         end
      end
   end

   // Grant, address and write data are latched once at the IDLE edge and held for the whole cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_grant     <= GrantIf;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_if_inst   <= '0;
         r_mem_rdata <= '0;
      end else begin
         if (r_state == Ram2Idle) begin
            if (mem_req) begin
               r_grant <= GrantMem;
               r_addr  <= SRAM_AW'(mem_addr);
               r_wdata <= mem_wdata;
            end else if (if_req) begin
               r_grant <= GrantIf;
               r_addr  <= SRAM_AW'(if_addr);
               if (w_ibuf_hit) r_if_inst <= w_ibuf_data;
            end
         end
         if (w_rd_last) begin
            if (r_grant == GrantMem) r_mem_rdata <= sram_dq_i;
            else                     r_if_inst   <= sram_dq_i;
         end
      end
   end

   assign sram_en_n  = !((r_state == Ram2Read) || (r_state == Ram2Write));
   assign sram_oe_n  = !(r_state == Ram2Read);
   assign sram_we_n  = !((r_state == Ram2Write) && (r_cnt != WR_LAST));
   assign sram_dq_oe = (r_state == Ram2Write);
   assign sram_addr  = r_addr;
   assign sram_dq_o  = r_wdata;

   assign if_ready  = (r_state == Ram2Done) && (r_grant == GrantIf);
   assign mem_ready = (r_state == Ram2Done) && (r_grant == GrantMem);
   assign if_inst   = r_if_inst;
   assign mem_rdata = r_mem_rdata;
   assign stall_req = (if_req & ~if_ready) | (mem_req & ~mem_ready);

endmodule

// File: tb/tb_ram2_arbiter.sv
// Self-checking bench for ram2_arbiter (default build) with a behavioural SRAM and a response scoreboard.
module tb_ram2_arbiter;

   typedef struct packed {
      logic        is_mem;
      logic [15:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, mem_req, mem_we;
   logic [15:0] if_addr, mem_addr, mem_wdata;
   logic [15:0] if_inst, mem_rdata;
   logic        if_ready, mem_ready, stall_req;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_i, sram_dq_o;
   logic        sram_dq_oe, sram_en_n, sram_oe_n, sram_we_n;

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   logic [15:0] exp_mem_rdata = 16'h0000;
   exp_t        sb[$];
   logic [15:0] sram [0:1023];

   ram2_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_inst    (if_inst),
      .if_ready   (if_ready),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .stall_req  (stall_req),
      .sram_addr  (sram_addr),
      .sram_dq_i  (sram_dq_i),
      .sram_dq_o  (sram_dq_o),
      .sram_dq_oe (sram_dq_oe),
      .sram_en_n  (sram_en_n),
      .sram_oe_n  (sram_oe_n),
      .sram_we_n  (sram_we_n)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (!sram_en_n && !sram_we_n) sram[sram_addr[9:0]] <= sram_dq_o;
   end
   assign sram_dq_i = (!sram_en_n && !sram_oe_n) ? sram[sram_addr[9:0]] : 16'hxxxx;

   function automatic logic [15:0] init_val(input logic [15:0] a);
      if (a == 16'h0003) return 16'h6911;
      return (a * 16'h0007) ^ 16'hC35A;
   endfunction

   task automatic monitor();
      exp_t        e;
      logic [15:0] got;
      forever begin
         @(negedge clk);
         if (rst && (if_ready || mem_ready)) begin
            checks++;
            if (if_ready && mem_ready) begin
               failures++;
               $display("FAIL both_ready if_ready=%b mem_ready=%b required one-hot", if_ready, mem_ready);
            end else if (sb.size() == 0) begin
               failures++;
               $display("FAIL unexpected_ready if_ready=%b mem_ready=%b required none", if_ready, mem_ready);
            end else begin
               e   = sb.pop_front();
               got = mem_ready ? mem_rdata : if_inst;
               if (e.is_mem !== mem_ready || got !== e.data) begin
                  failures++;
                  $display("FAIL sb_data owner_mem=%b data=%h required owner_mem=%b data=%h",
                           mem_ready, got, e.is_mem, e.data);
               end
            end
         end
      end
   endtask

   // Drives one request at posedge+1 in an IDLE cycle, waits for its ready, drops it at the next posedge+1.
   task automatic issue(input logic is_mem, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_rd,
                        output int lat, output int n_rd, output int n_wlo, output int n_oe,
                        output logic bus_ok, output logic stall_ok);
      exp_t e;
      lat = -1; n_rd = 0; n_wlo = 0; n_oe = 0; bus_ok = 1'b1; stall_ok = 1'b1;
      if (is_mem) begin
         mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
         if (!we) exp_mem_rdata = exp_rd;
         e.is_mem = 1'b1; e.data = exp_mem_rdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
         e.is_mem = 1'b0; e.data = exp_rd;
      end
      sb.push_back(e);
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         if (!sram_en_n && !sram_oe_n) n_rd++;
         if (!sram_en_n && !sram_we_n) n_wlo++;
         if (sram_dq_oe) n_oe++;
         if (!sram_en_n && sram_addr !== {2'b00, addr}) bus_ok = 1'b0;
         if (sram_dq_oe && sram_dq_o !== wdata) bus_ok = 1'b0;
         if (i == 0 && stall_req !== 1'b1) stall_ok = 1'b0;
         if (is_mem ? mem_ready : if_ready) begin
            if (stall_req !== 1'b0) stall_ok = 1'b0;
            lat = i;
            break;
         end
      end
      @(posedge clk); #1;
      if (is_mem) mem_req = 1'b0;
      else        if_req  = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({sram_en_n, sram_oe_n, sram_we_n, sram_dq_oe, if_ready, mem_ready, stall_req} !== 7'b1110000) begin
         failures++;
         $display("FAIL reset_strobes got=%b required=1110000",
                  {sram_en_n, sram_oe_n, sram_we_n, sram_dq_oe, if_ready, mem_ready, stall_req});
      end
      checks++;
      if ({sram_addr, sram_dq_o, if_inst, mem_rdata} !== '0) begin
         failures++;
         $display("FAIL reset_data addr=%h dq_o=%h if_inst=%h mem_rdata=%h required all 0",
                  sram_addr, sram_dq_o, if_inst, mem_rdata);
      end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_if_read();
      int lat, n_rd, n_wlo, n_oe; logic bus_ok, stall_ok;
      issue(1'b0, 1'b0, 16'h0003, 16'h0000, 16'h6911, lat, n_rd, n_wlo, n_oe, bus_ok, stall_ok);
      checks++;
      if (lat !== 3) begin failures++; $display("FAIL if_read_latency got=%0d required=3", lat); end
      checks++;
      if ({n_rd, n_wlo, n_oe} !== {32'd2, 32'd0, 32'd0}) begin
         failures++; $display("FAIL if_read_strobes rd=%0d we=%0d oe=%0d required 2/0/0", n_rd, n_wlo, n_oe);
      end
      checks++;
      if ({bus_ok, stall_ok} !== 2'b11) begin
         failures++; $display("FAIL if_read_bus_stall got=%b required=11", {bus_ok, stall_ok});
      end
   endtask

   task automatic test_mem_write_read();
      int lat, n_rd, n_wlo, n_oe; logic bus_ok, stall_ok;
      issue(1'b1, 1'b1, 16'h0100, 16'hBEEF, 16'h0000, lat, n_rd, n_wlo, n_oe, bus_ok, stall_ok);
      checks++;
      if (lat !== 4) begin failures++; $display("FAIL mem_write_latency got=%0d required=4", lat); end
      checks++;
      if ({n_rd, n_wlo, n_oe} !== {32'd0, 32'd2, 32'd3}) begin
         failures++; $display("FAIL mem_write_strobes rd=%0d we=%0d oe=%0d required 0/2/3", n_rd, n_wlo, n_oe);
      end
      checks++;
      if ({bus_ok, stall_ok} !== 2'b11) begin
         failures++; $display("FAIL mem_write_bus_stall got=%b required=11", {bus_ok, stall_ok});
      end
      issue(1'b1, 1'b0, 16'h0100, 16'h0000, 16'hBEEF, lat, n_rd, n_wlo, n_oe, bus_ok, stall_ok);
      checks++;
      if (lat !== 3 || n_rd !== 2) begin
         failures++; $display("FAIL mem_read_back latency=%0d rd=%0d required 3/2", lat, n_rd);
      end
   endtask

   task automatic test_contention();
      exp_t e;
      int t_mem = -1, t_if = -1;
      logic stall_mid = 1'b0;
      exp_mem_rdata = init_val(16'h0020);
      e.is_mem = 1'b1; e.data = exp_mem_rdata;  sb.push_back(e);
      e.is_mem = 1'b0; e.data = init_val(16'h0010); sb.push_back(e);
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0020;
      if_req  = 1'b1; if_addr = 16'h0010;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         if (mem_ready && t_mem < 0) begin t_mem = i; stall_mid = stall_req; end
         if (if_ready && t_if < 0) t_if = i;
         @(posedge clk); #1;
         if (t_mem >= 0) mem_req = 1'b0;
         if (t_if >= 0) begin if_req = 1'b0; break; end
      end
      checks++;
      if (t_mem !== 3 || t_if !== 7) begin
         failures++; $display("FAIL contention_order mem_at=%0d if_at=%0d required 3/7", t_mem, t_if);
      end
      checks++;
      if (stall_mid !== 1'b1) begin
         failures++; $display("FAIL contention_stall got=%b required=1 while IF waits", stall_mid);
      end
      if_req = 1'b0; mem_req = 1'b0;
   endtask

   task automatic test_reset_mid_write();
      int n_ready = 0;
      int lat, n_rd, n_wlo, n_oe; logic bus_ok, stall_ok;
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h0200; mem_wdata = 16'h1111;
      @(posedge clk); #2;
      checks++;
      if (sram_we_n !== 1'b0) begin failures++; $display("FAIL mid_write_entry we_n=%b required=0", sram_we_n); end
      rst = 1'b0;
      #1;
      checks++;
      if ({sram_en_n, sram_oe_n, sram_we_n, sram_dq_oe, if_ready, mem_ready} !== 6'b111000) begin
         failures++;
         $display("FAIL mid_write_reset got=%b required=111000",
                  {sram_en_n, sram_oe_n, sram_we_n, sram_dq_oe, if_ready, mem_ready});
      end
      checks++;
      if ({if_inst, mem_rdata} !== 32'h0) begin
         failures++; $display("FAIL mid_write_reset_data if_inst=%h mem_rdata=%h required 0/0", if_inst, mem_rdata);
      end
      mem_req = 1'b0;
      exp_mem_rdata = 16'h0000;
      @(negedge clk); rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (mem_ready || if_ready) n_ready++;
      end
      checks++;
      if (n_ready !== 0 || sram[10'h200] !== init_val(16'h0200)) begin
         failures++;
         $display("FAIL abandoned_write readies=%0d sram=%h required 0/%h", n_ready, sram[10'h200], init_val(16'h0200));
      end
      @(posedge clk); #1;
      issue(1'b0, 1'b0, 16'h0007, 16'h0000, init_val(16'h0007), lat, n_rd, n_wlo, n_oe, bus_ok, stall_ok);
      checks++;
      if (lat !== 3) begin failures++; $display("FAIL post_reset_idle latency=%0d required=3", lat); end
   endtask

   task automatic test_back_to_back();
      int lat, n_rd, n_wlo, n_oe; logic bus_ok, stall_ok;
      int t_prev, t_now;
      t_prev = cyc;
      for (int a = 0; a < 3; a++) begin
         issue(1'b0, 1'b0, 16'(a), 16'h0000, init_val(16'(a)), lat, n_rd, n_wlo, n_oe, bus_ok, stall_ok);
         t_now = cyc;
         checks++;
         if (lat !== 3 || (t_now - t_prev) !== 4 || bus_ok !== 1'b1) begin
            failures++;
            $display("FAIL back_to_back_%0d latency=%0d spacing=%0d bus_ok=%b required 3/4/1", a, lat, t_now - t_prev, bus_ok);
         end
         t_prev = t_now;
      end
   endtask

   task automatic test_random();
      int lat, n_rd, n_wlo, n_oe; logic bus_ok, stall_ok;
      logic [15:0] d, a;
      for (int i = 0; i < 4; i++) begin
         d = 16'($urandom);
         a = 16'h0300 + 16'(i);
         issue(1'b1, 1'b1, a, d, 16'h0000, lat, n_rd, n_wlo, n_oe, bus_ok, stall_ok);
         checks++;
         if (lat !== 4 || bus_ok !== 1'b1) begin
            failures++; $display("FAIL rand_write_%0d latency=%0d bus_ok=%b required 4/1", i, lat, bus_ok);
         end
         a = 16'($urandom_range(0, 255));
         issue(1'b0, 1'b0, a, 16'h0000, init_val(a), lat, n_rd, n_wlo, n_oe, bus_ok, stall_ok);
         a = 16'h0300 + 16'(i);
         issue(1'b1, 1'b0, a, 16'h0000, d, lat, n_rd, n_wlo, n_oe, bus_ok, stall_ok);
         checks++;
         if (lat !== 3 || bus_ok !== 1'b1) begin
            failures++; $display("FAIL rand_read_%0d latency=%0d bus_ok=%b required 3/1", i, lat, bus_ok);
         end
      end
   endtask

   initial begin
      rst = 1'b0;
      if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
      if_addr = '0; mem_addr = '0; mem_wdata = '0;
      for (int i = 0; i < 1024; i++) sram[i] = init_val(i[15:0]);
      fork
         monitor();
      join_none
      test_reset();
      test_if_read();
      test_mem_write_read();
      test_contention();
      test_reset_mid_write();
      test_back_to_back();
      test_random();
      repeat (4) @(negedge clk);
      checks++;
      if (sb.size() !== 0) begin
         failures++; $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
